// File: rtl/spi_readout_sequencer_pkg.sv
// Shared types and constants for the SPI readout sequencer slice.
package spi_readout_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_ADDR = 3'd1,
        WAIT     = 3'd2,
        LOAD     = 3'd3,
        SHIFT    = 3'd4,
        NEXT     = 3'd5
    } seq_state_t;

    // Bits per serialised byte
    localparam int BYTE_BITS   = 8;
    // Settle cycles after an address strobe before out_byte is sampled
    localparam int WAIT_CYCLES = 2;

endpackage

// File: rtl/spi_readout_sequencer_input_sync.sv
// Multi-flop synchroniser for an asynchronous SPI pin, followed by a
// registered rise/fall detector producing single-cycle edge pulses.
// The chain resets to 0 so that a CS_N held low through reset never
// produces a spurious falling edge on reset release.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchronise the pin and register one-cycle edge pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[SYNC_STAGES-1] & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/spi_readout_sequencer.sv
// SPI mode-0 read-only slave that streams the latched sweep-timing byte
// memory to the host, and arbitrates snapshot latching so a snapshot never
// changes while chip select is asserted.
module spi_readout_sequencer
    import spi_readout_sequencer_pkg::*;
#(
    parameter int NUM_BYTES   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] mem_byte,
    output logic       mem_latch,
    output logic       mem_reset_addr,
    output logic       mem_incr,
    output logic       busy,
    output logic       frame_done,
    output logic       sample_dropped
);

    localparam int BYTE_CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic                  sck_fall_s;
    logic                  unused_sck_rise_s;
    logic                  cs_rise_s;
    logic                  cs_fall_s;

    seq_state_t            state_r;
    logic [BYTE_BITS-1:0]  sr_r;
    logic [3:0]            bit_cnt_r;
    logic [BYTE_CNT_W-1:0] byte_cnt_r;
    logic [1:0]            wait_cnt_r;
    logic                  pending_r;
    logic                  miso_oe_r;
    logic                  busy_r;
    logic                  mem_latch_r;
    logic                  mem_reset_addr_r;
    logic                  mem_incr_r;
    logic                  frame_done_r;
    logic                  sample_dropped_r;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sck),
        .rise (unused_sck_rise_s),
        .fall (sck_fall_s)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .rise (cs_rise_s),
        .fall (cs_fall_s)
    );

    // Transaction FSM, snapshot arbitration and registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r          <= IDLE;
            sr_r             <= '0;
            bit_cnt_r        <= 4'd0;
            byte_cnt_r       <= '0;
            wait_cnt_r       <= 2'd0;
            pending_r        <= 1'b0;
            miso_oe_r        <= 1'b0;
            busy_r           <= 1'b0;
            mem_latch_r      <= 1'b0;
            mem_reset_addr_r <= 1'b0;
            mem_incr_r       <= 1'b0;
            frame_done_r     <= 1'b0;
            sample_dropped_r <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            mem_latch_r      <= 1'b0;
            mem_reset_addr_r <= 1'b0;
            mem_incr_r       <= 1'b0;
            frame_done_r     <= 1'b0;
            sample_dropped_r <= 1'b0;

            case (state_r)
                IDLE: begin
                    miso_oe_r <= 1'b0;
                    if (cs_fall_s) begin
                        // Transaction wins; a coincident sample is deferred
                        state_r <= RST_ADDR;
                        busy_r  <= 1'b1;
                        if (sample_valid) begin
                            pending_r <= 1'b1;
                            if (pending_r) begin
                                sample_dropped_r <= 1'b1;
                            end
                        end
                    end else if (sample_valid || pending_r) begin
                        mem_latch_r <= 1'b1;
                        pending_r   <= 1'b0;
                    end
                end

                default: begin
                    // Snapshot requests during a transaction are held back
                    if (sample_valid) begin
                        pending_r <= 1'b1;
                        if (pending_r) begin
                            sample_dropped_r <= 1'b1;
                        end
                    end

                    if (cs_rise_s) begin
                        // Host released CS: discard any partial byte
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                        sr_r      <= '0;
                        bit_cnt_r <= 4'd0;
                    end else begin
                        case (state_r)
                            RST_ADDR: begin
                                mem_reset_addr_r <= 1'b1;
                                byte_cnt_r       <= '0;
                                wait_cnt_r       <= 2'd0;
                                state_r          <= WAIT;
                            end
                            WAIT: begin
                                if (wait_cnt_r == 2'(WAIT_CYCLES - 1)) begin
                                    state_r <= LOAD;
                                end else begin
                                    wait_cnt_r <= wait_cnt_r + 2'd1;
                                end
                            end
                            LOAD: begin
                                sr_r      <= mem_byte;
                                bit_cnt_r <= 4'd0;
                                miso_oe_r <= 1'b1;
                                state_r   <= SHIFT;
                            end
                            SHIFT: begin
                                if (sck_fall_s) begin
                                    sr_r      <= {sr_r[BYTE_BITS-2:0], 1'b0};
                                    bit_cnt_r <= bit_cnt_r + 4'd1;
                                    if (bit_cnt_r == 4'(BYTE_BITS - 1)) begin
                                        state_r <= NEXT;
                                    end
                                end
                            end
                            NEXT: begin
                                mem_incr_r <= 1'b1;
                                wait_cnt_r <= 2'd0;
                                if (byte_cnt_r == BYTE_CNT_W'(NUM_BYTES - 1)) begin
                                    frame_done_r <= 1'b1;
                                    byte_cnt_r   <= '0;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + 1'b1;
                                end
                                state_r <= WAIT;
                            end
                            default: begin
                                state_r   <= IDLE;
                                busy_r    <= 1'b0;
                                miso_oe_r <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign spi_miso       = sr_r[BYTE_BITS-1];
    assign spi_miso_oe    = miso_oe_r;
    assign busy           = busy_r;
    assign mem_latch      = mem_latch_r;
    assign mem_reset_addr = mem_reset_addr_r;
    assign mem_incr       = mem_incr_r;
    assign frame_done     = frame_done_r;
    assign sample_dropped = sample_dropped_r;

endmodule

// File: tb/tb_spi_readout_sequencer.sv
// Scoreboard bench for spi_readout_sequencer: a behavioural byte memory,
// a host-side SPI driver, and decoupled monitors that pop expected events.
module tb_spi_readout_sequencer;

    localparam int FRAME_BITS = 64;
    localparam int EXP_NONE   = 0;
    localparam int EXP_LATCH  = 1;
    localparam int EXP_DROP   = 2;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] mem_byte;
    logic       mem_latch;
    logic       mem_reset_addr;
    logic       mem_incr;
    logic       busy;
    logic       frame_done;
    logic       sample_dropped;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int incr_cnt = 0;
    int ra_cnt   = 0;

    win_t       latch_q[$];
    win_t       drop_q[$];
    win_t       done_q[$];
    logic [7:0] byte_q[$];

    always #5 clk = ~clk;

    spi_readout_sequencer #(.NUM_BYTES(8), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .spi_sck        (spi_sck),
        .spi_cs_n       (spi_cs_n),
        .spi_miso       (spi_miso),
        .spi_miso_oe    (spi_miso_oe),
        .mem_byte       (mem_byte),
        .mem_latch      (mem_latch),
        .mem_reset_addr (mem_reset_addr),
        .mem_incr       (mem_incr),
        .busy           (busy),
        .frame_done     (frame_done),
        .sample_dropped (sample_dropped)
    );

    // Behavioural byte memory: live values, latched snapshot, wrapping address
    logic [7:0] live_mem [8];
    logic [7:0] snap_mem [8];
    logic [2:0] mem_addr = 3'd0;

    always @(posedge clk) begin
        if (mem_latch) begin
            for (int i = 0; i < 8; i++) snap_mem[i] <= live_mem[i];
        end
        if (mem_reset_addr) mem_addr <= 3'd0;
        else if (mem_incr) mem_addr <= mem_addr + 3'd1;
    end
    assign mem_byte = snap_mem[mem_addr];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic win_t mk_win(input int lo, input int hi);
        win_t w;
        w.lo = lo;
        w.hi = hi;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_win(input string name, input win_t w);
        n_cmp++;
        if (cyc < w.lo || cyc > w.hi) begin
            n_fail++;
            $display("FAIL %s: seen at cycle %0d, expected within [%0d,%0d]", name, cyc, w.lo, w.hi);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: pulse at cycle %0d, expected none", name, cyc);
    endtask

    // Strobe monitor: every output pulse must match a queued expectation
    always @(negedge clk) begin
        if (mem_incr) incr_cnt++;
        if (mem_reset_addr) ra_cnt++;
        if (mem_latch) begin
            if (latch_q.size() == 0) unexpected("mem_latch");
            else check_win("mem_latch", latch_q.pop_front());
        end
        if (sample_dropped) begin
            if (drop_q.size() == 0) unexpected("sample_dropped");
            else check_win("sample_dropped", drop_q.pop_front());
        end
        if (frame_done) begin
            if (done_q.size() == 0) unexpected("frame_done");
            else check_win("frame_done", done_q.pop_front());
        end
    end

    // Host receiver: sample MISO at the end of each SCK high phase
    logic [7:0] rx_byte  = 8'd0;
    int         rx_bits  = 0;
    logic       rx_oe_ok = 1'b1;

    always @(negedge spi_sck) begin
        if (rst === 1'b1 && spi_cs_n === 1'b0) begin
            rx_byte  = {rx_byte[6:0], spi_miso};
            rx_oe_ok = rx_oe_ok & spi_miso_oe;
            rx_bits++;
            if (rx_bits == 8) begin
                if (byte_q.size() == 0) unexpected("miso_byte");
                else check("miso_byte{oe,data}", {23'd0, rx_oe_ok, rx_byte}, {23'd0, 1'b1, byte_q.pop_front()});
                rx_bits  = 0;
                rx_oe_ok = 1'b1;
            end
        end
    end

    always @(posedge spi_cs_n) begin
        rx_bits  = 0;
        rx_oe_ok = 1'b1;
    end

    task automatic fill_live(input logic [7:0] first, input logic [7:0] step);
        for (int k = 0; k < 8; k++) live_mem[k] = 8'(first + step * k);
    endtask

    task automatic push_bytes(input logic [7:0] first, input logic [7:0] step, input int n);
        for (int k = 0; k < n; k++) byte_q.push_back(8'(first + step * (k % 8)));
    endtask

    task automatic sck_bits(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1 spi_sck = 1'b1;
            repeat (5) @(posedge clk);
            #1 spi_sck = 1'b0;
            if (i == FRAME_BITS) done_q.push_back(mk_win(cyc + 1, cyc + 10));
            repeat (4) @(posedge clk);
        end
    endtask

    task automatic pulse_sample(input int kind);
        @(posedge clk); #1 sample_valid = 1'b1;
        if (kind == EXP_LATCH) latch_q.push_back(mk_win(cyc + 1, cyc + 1));
        else if (kind == EXP_DROP) drop_q.push_back(mk_win(cyc + 1, cyc + 1));
        @(posedge clk); #1 sample_valid = 1'b0;
    endtask

    task automatic cs_assert();
        @(posedge clk); #1 spi_cs_n = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic cs_release(input bit expect_latch);
        @(posedge clk); #1 spi_cs_n = 1'b1;
        if (expect_latch) latch_q.push_back(mk_win(cyc + 1, cyc + 10));
        repeat (15) @(posedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        spi_cs_n     = 1'b0;
        spi_sck      = 1'b0;
        sample_valid = 1'b0;
        for (int k = 0; k < 8; k++) snap_mem[k] = 8'd0;
        fill_live(8'h11, 8'h11);

        // Reset with CS low and SCK toggling: every output must be 0
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 spi_sck = ~spi_sck;
        end
        @(negedge clk);
        check("reset_outputs", {24'd0, spi_miso, spi_miso_oe, mem_latch, mem_reset_addr,
                                mem_incr, busy, frame_done, sample_dropped}, 32'd0);
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Idle latch: one strobe on the next clock, no drop
        pulse_sample(EXP_LATCH);
        repeat (4) @(posedge clk);

        // Full frame with three mid-frame samples -> two drops, latch after CS
        incr_cnt = 0;
        ra_cnt   = 0;
        push_bytes(8'h11, 8'h11, 8);
        cs_assert();
        fork
            sck_bits(FRAME_BITS);
            begin
                repeat (100) @(posedge clk);
                fill_live(8'hA1, 8'h01);
                pulse_sample(EXP_NONE);
                repeat (60) @(posedge clk);
                pulse_sample(EXP_DROP);
                repeat (60) @(posedge clk);
                pulse_sample(EXP_DROP);
            end
        join
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("frame_incr_count", incr_cnt, 32'd8);
        check("frame_reset_addr_count", ra_cnt, 32'd1);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        cs_release(1'b1);
        @(negedge clk);
        check("busy_after_release", {31'd0, busy}, 32'd0);
        check("oe_after_release", {31'd0, spi_miso_oe}, 32'd0);

        // Deferred snapshot is now visible to the host
        push_bytes(8'hA1, 8'h01, 8);
        cs_assert();
        sck_bits(FRAME_BITS);
        cs_release(1'b0);

        // Restore original values through an idle latch
        fill_live(8'h11, 8'h11);
        pulse_sample(EXP_LATCH);
        repeat (4) @(posedge clk);

        // Abort after 13 bits: no frame_done, OE drops
        push_bytes(8'h11, 8'h11, 1);
        cs_assert();
        sck_bits(13);
        @(negedge clk);
        check("oe_during_frame", {31'd0, spi_miso_oe}, 32'd1);
        cs_release(1'b0);
        @(negedge clk);
        check("oe_after_abort", {31'd0, spi_miso_oe}, 32'd0);
        check("busy_after_abort", {31'd0, busy}, 32'd0);

        // 72-bit frame restarts at 0x11 and wraps to 0x11 as the ninth byte
        incr_cnt = 0;
        push_bytes(8'h11, 8'h11, 9);
        cs_assert();
        sck_bits(72);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("wrap_incr_count", incr_cnt, 32'd9);
        cs_release(1'b0);

        // Reset during byte 3 with a pending sample: pending is lost
        push_bytes(8'h11, 8'h11, 2);
        cs_assert();
        sck_bits(10);
        pulse_sample(EXP_NONE);
        sck_bits(9);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_in_reset", {31'd0, busy}, 32'd0);
        check("oe_in_reset", {31'd0, spi_miso_oe}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        cs_release(1'b0);
        repeat (20) @(posedge clk);

        // Every queued expectation must have been consumed
        @(negedge clk);
        check("latch_q_left", latch_q.size(), 32'd0);
        check("drop_q_left", drop_q.size(), 32'd0);
        check("done_q_left", done_q.size(), 32'd0);
        check("byte_q_left", byte_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
